// File: rtl/hack_pkg.sv
// Shared definitions for the Hack datapath blocks: default word width and
// the state encoding used by the bit-serial adder.
package hack_pkg;

  localparam int WORD_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell: sum and carry of three input bits.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder16.sv
// Bit-serial two's-complement adder: one full-adder cell plus a carry flop,
// adding LSB-first over WORD_WIDTH clocks.
module serial_adder16
  import hack_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] sum,
  output logic                  cout,
  output logic                  overflow
);

  // Handshake: start is accepted only when the block is idle (!busy && !done);
  // a, b and cin are captured on that edge. busy then stays high for exactly
  // WORD_WIDTH cycles, followed by a single-cycle done pulse. start while busy
  // or done is ignored. sum/cout/overflow hold until the next done.

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_BIT   = CW'(WORD_WIDTH - 1);
  localparam logic [CW-1:0] PENULT_BIT = CW'(WORD_WIDTH - 2);

  serial_state_t state;
  serial_state_t state_next;

  logic [WORD_WIDTH-1:0] a_sr;
  logic [WORD_WIDTH-1:0] b_sr;
  logic [WORD_WIDTH-2:0] sum_sr;
  logic                  carry;
  logic                  c_msb_in;
  logic [CW-1:0]         count;

  logic                  fa_sum;
  logic                  fa_carry;
  logic [WORD_WIDTH-1:0] sum_shift;

  fulladder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Partial sum with the current bit entering at the MSB; on the last RUN
  // cycle this is the complete result.
  assign sum_shift = {fa_sum, sum_sr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      count    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            count    <= '0;
            sum_sr   <= '0;
            c_msb_in <= 1'b0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift[WORD_WIDTH-1:1];
          carry  <= fa_carry;
          // Carry out of bit WORD_WIDTH-2 is the carry into the MSB.
          if (count == PENULT_BIT) begin
            c_msb_in <= fa_carry;
          end
          if (count == LAST_BIT) begin
            sum      <= sum_shift;
            cout     <= fa_carry;
            overflow <= c_msb_in ^ fa_carry;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
